// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: hex glyph table
// and the dark pattern, both active-high in {g,f,e,d,c,b,a} order.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Index 0 is the rightmost entry.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-high seven-segment glyph (0-9, A, b, C, d, E, F).
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = SEG_HEX[nibble];

endmodule

// File: rtl/seg_mux_driver.sv
// Time-multiplexed seven-segment scanner with PWM brightness, blanking and tear-free
// frame updates. Optional decimal point path is enabled by defining SEG_MUX_DP_EN.
module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   digits_i,
  input  logic                    load,
  input  logic [N_DIGITS-1:0]     blank_mask,
  input  logic [3:0]              bright,
`ifdef SEG_MUX_DP_EN
  input  logic [N_DIGITS-1:0]     dp_i,
  output logic                    dp,
`endif
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_done
);

  localparam int   IW  = $clog2(N_DIGITS);
  localparam int   SW  = $clog2(REFRESH_DIV);
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [SW-1:0]         slot_cnt;
  logic [3:0]            pwm_cnt;
  logic [IW-1:0]         index;
  logic [4*N_DIGITS-1:0] stage;
  logic [4*N_DIGITS-1:0] display;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic                  lit;
  logic [3:0]            cur_nibble;
  logic [6:0]            cur_seg;
  logic [N_DIGITS-1:0]   an_act;

  assign slot_wrap  = (slot_cnt == SW'(REFRESH_DIV - 1));
  assign frame_wrap = slot_wrap && (index == IW'(N_DIGITS - 1));
  assign cur_nibble = display[4*index +: 4];

  // Dead time at slot start keeps the previous digit's charge from ghosting.
  assign lit = (slot_cnt >= SW'(BLANK_CYC)) && (pwm_cnt < bright) && !blank_mask[index];

  assign an_act = lit ? (N_DIGITS'(1) << index) : '0;

  seg_hex_decoder u_dec (
    .nibble (cur_nibble),
    .segs   (cur_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      pwm_cnt  <= '0;
      index    <= '0;
    end else begin
      pwm_cnt  <= pwm_cnt + 4'd1;
      slot_cnt <= slot_wrap ? '0 : slot_cnt + SW'(1);
      if (slot_wrap) begin
        index <= (index == IW'(N_DIGITS - 1)) ? '0 : index + IW'(1);
      end
    end
  end

  // Display only changes between frames; a load on the boundary cycle bypasses stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage   <= '0;
      display <= '0;
    end else begin
      if (load) begin
        stage <= digits_i;
      end
      if (frame_wrap) begin
        display <= load ? digits_i : stage;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= SEG_OFF ^ {7{INV}};
      an         <= {N_DIGITS{INV}};
      frame_done <= 1'b0;
    end else begin
      seg        <= (lit ? cur_seg : SEG_OFF) ^ {7{INV}};
      an         <= an_act ^ {N_DIGITS{INV}};
      frame_done <= frame_wrap;
    end
  end

`ifdef SEG_MUX_DP_EN
  logic [N_DIGITS-1:0] dp_stage;
  logic [N_DIGITS-1:0] dp_display;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_stage   <= '0;
      dp_display <= '0;
      dp         <= INV;
    end else begin
      if (load) begin
        dp_stage <= dp_i;
      end
      if (frame_wrap) begin
        dp_display <= load ? dp_i : dp_stage;
      end
      dp <= (lit && dp_display[index]) ^ INV;
    end
  end
`endif

endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed bench for seg_mux_driver with 4 digits, 8-cycle slots, 2 dark cycles, active-low.
module tb_seg_mux_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_i;
  logic        load;
  logic [3:0]  blank_mask;
  logic [3:0]  bright;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seg_mux_driver #(
    .N_DIGITS    (4),
    .REFRESH_DIV (8),
    .BLANK_CYC   (2),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_i   (digits_i),
    .load       (load),
    .blank_mask (blank_mask),
    .bright     (bright),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Outputs sampled on the falling edge; cyc counts rising edges since reset release.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic expect_out(input string tag, input int k, input logic [3:0] a, input logic [6:0] s);
    wait_to(k);
    check({tag, "_an"}, 32'(an), 32'(a));
    check({tag, "_seg"}, 32'(seg), 32'(s));
  endtask

  task automatic expect_fd(input string tag, input int k, input logic v);
    wait_to(k);
    check(tag, 32'(frame_done), 32'(v));
  endtask

  task automatic count_active(input int n, output int c);
    c = 0;
    repeat (n) begin
      tick();
      if (an !== 4'b1111) c++;
    end
  endtask

  int c;

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    digits_i   = 16'h0000;
    blank_mask = 4'b0000;
    bright     = 4'd15;
    repeat (2) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;
    cyc = 0;

    // Frame 1: cleared display shows glyph 0; load 4321 for the next frame.
    expect_out("f1_d0", 5, 4'b1110, 7'h40);
    digits_i = 16'h4321;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    expect_fd("fd_31", 31, 1'b0);
    expect_fd("fd_32", 32, 1'b1);
    expect_fd("fd_33", 33, 1'b0);
    expect_out("f2_dark0", 33, 4'b1111, 7'h7F);
    expect_out("f2_dark1", 34, 4'b1111, 7'h7F);
    expect_out("f2_d0", 35, 4'b1110, 7'h79);
    expect_out("f2_d1", 45, 4'b1101, 7'h24);
    expect_out("f2_d2", 53, 4'b1011, 7'h30);
    expect_out("f2_d3", 61, 4'b0111, 7'h19);
    expect_fd("fd_64", 64, 1'b1);

    // Mid-frame load must not tear the frame in progress.
    wait_to(70);
    digits_i = 16'hFEDC;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    expect_out("f3_d2_old", 85, 4'b1011, 7'h30);
    expect_out("f3_d3_old", 93, 4'b0111, 7'h19);
    expect_out("f4_d0_C", 101, 4'b1110, 7'h46);
    expect_out("f4_d1_d", 109, 4'b1101, 7'h21);
    expect_out("f4_d2_E", 117, 4'b1011, 7'h06);
    expect_out("f4_d3_F", 125, 4'b0111, 7'h0E);

    wait_to(128);
    blank_mask = 4'b0100;
    expect_out("mask_d1", 141, 4'b1101, 7'h21);
    expect_out("mask_d2", 149, 4'b1111, 7'h7F);
    expect_out("mask_d3", 157, 4'b0111, 7'h0E);

    wait_to(160);
    blank_mask = 4'b0000;
    bright     = 4'd4;
    count_active(32, c);
    check("bright4_cnt", 32'(c), 32'd4);
    bright = 4'd0;
    count_active(32, c);
    check("bright0_cnt", 32'(c), 32'd0);
    bright = 4'd15;

    // Load on the boundary cycle goes straight to display, skipping stale stage.
    wait_to(255);
    digits_i = 16'h0A0A;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    check("fd_256", 32'(frame_done), 32'h1);
    expect_out("bnd_d0_A", 261, 4'b1110, 7'h08);
    expect_out("bnd_d1_0", 269, 4'b1101, 7'h40);
    expect_out("bnd_d2_A", 277, 4'b1011, 7'h08);
    expect_out("bnd_d3_0", 285, 4'b0111, 7'h40);

    // Reset while digit 2 is lit.
    expect_out("pre_rst_d2", 307, 4'b1011, 7'h08);
    rst = 1'b1;
    #1;
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    expect_out("restart_dark", 2, 4'b1111, 7'h7F);
    expect_out("restart_d0", 3, 4'b1110, 7'h40);
    expect_fd("restart_fd31", 31, 1'b0);
    expect_fd("restart_fd32", 32, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
